// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel LED engine with off/on/blink/PWM modes, force override and toggle ticks
// Ports: clk, rst (async, active-high); cfg_we/cfg_ch/cfg_mode/cfg_half_period/cfg_duty write one
// channel's config; sync_restart clears all counters and phases; force_en/force_val override led;
// led is the registered LED vector; tick pulses one cycle on every blink phase toggle.
module led_blink_multi #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned CNT_W           = 25,
    parameter int unsigned DUTY_W          = 8,
    parameter logic [1:0]  RST_MODE        = 2'b10,
    parameter int unsigned RST_HALF_PERIOD = 2**24 - 1,
    localparam int unsigned CH_W           = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half_period,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic              sync_restart,
    input  logic [NUM_CH-1:0] force_en,
    input  logic [NUM_CH-1:0] force_val,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] tick
);
    logic [1:0]        mode_q [NUM_CH];
    logic [1:0]        mode_d [NUM_CH];
    logic [CNT_W-1:0]  half_q [NUM_CH];
    logic [CNT_W-1:0]  half_d [NUM_CH];
    logic [DUTY_W-1:0] duty_q [NUM_CH];
    logic [DUTY_W-1:0] duty_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] phase_q, phase_d, led_q, led_d, tick_q, tick_d;
    logic [NUM_CH-1:0] wr, tc, run;
    logic [DUTY_W-1:0] pwm_q, pwm_d;
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i]  = cfg_we && cfg_ch == CH_W'(i);
            tc[i]  = cnt_q[i] == half_q[i];
            // a write or restart on this edge overrides counting, so the terminal count is swallowed
            run[i] = mode_q[i] == 2'b10 && !wr[i] && !sync_restart;
        end
    end
    always_comb begin
        pwm_d = sync_restart ? '0 : pwm_q + DUTY_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i]  = wr[i] ? cfg_mode : mode_q[i];
            half_d[i]  = wr[i] ? cfg_half_period : half_q[i];
            duty_d[i]  = wr[i] ? cfg_duty : duty_q[i];
            cnt_d[i]   = run[i] ? (tc[i] ? '0 : cnt_q[i] + CNT_W'(1)) : '0;
            phase_d[i] = run[i] && (phase_q[i] ^ tc[i]);
            tick_d[i]  = run[i] && tc[i];
        end
    end
    // blink follows the freshly computed phase; PWM compares against the pre-edge shared counter
    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            led_d[i] = force_en[i]          ? force_val[i] :
                       mode_q[i] == 2'b00   ? 1'b0 :
                       mode_q[i] == 2'b01   ? 1'b1 :
                       mode_q[i] == 2'b10   ? phase_d[i] :
                                              pwm_q < duty_q[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= RST_MODE;
                half_q[i] <= CNT_W'(RST_HALF_PERIOD >> i);
                duty_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            phase_q <= '0;
            led_q   <= '0;
            tick_q  <= '0;
            pwm_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
        end
    end
    assign led  = led_q;
    assign tick = tick_q;
endmodule

// File: tb/tb_led_blink_multi.sv
// tb_led_blink_multi: directed vector bench for led_blink_multi
module tb_led_blink_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_half = '0;
    logic [7:0] cfg_duty = '0;
    logic       sync_restart = 1'b0;
    logic [3:0] force_en = '0;
    logic [3:0] force_val = '0;
    logic [3:0] led, tick;
    logic       cfg_we2 = 1'b0;
    logic [2:0] cfg_ch2 = '0;
    logic [5:0] led2, tick2;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_blink_multi #(.NUM_CH(4), .CNT_W(8), .DUTY_W(8), .RST_MODE(2'b10), .RST_HALF_PERIOD(7)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_half_period(cfg_half), .cfg_duty(cfg_duty), .sync_restart(sync_restart),
        .force_en(force_en), .force_val(force_val), .led(led), .tick(tick));

    led_blink_multi #(.NUM_CH(6), .CNT_W(8), .DUTY_W(8), .RST_MODE(2'b10), .RST_HALF_PERIOD(7)) dut6 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2), .cfg_mode(cfg_mode),
        .cfg_half_period(cfg_half), .cfg_duty(cfg_duty), .sync_restart(1'b0),
        .force_en(6'b0), .force_val(6'b0), .led(led2), .tick(tick2));

    typedef struct {
        logic [3:0] fe;
        logic [3:0] fv;
        logic [3:0] led;
        logic [3:0] tick;
    } vec_t;

    vec_t va [16];
    vec_t vb [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int k);
        force_en  = v.fe;
        force_val = v.fv;
        @(posedge clk); #1;
        check($sformatf("%s[%0d] led", tag, k), 32'(led), 32'(v.led));
        check($sformatf("%s[%0d] tick", tag, k), 32'(tick), 32'(v.tick));
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] half, input logic [7:0] duty);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_duty = duty;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic count_pwm(input string name, input int exp);
        int hi = 0;
        for (int j = 0; j < 256; j++) begin
            @(posedge clk); #1;
            hi += int'(led[2]);
        end
        check(name, 32'(hi), 32'(exp));
    endtask

    initial begin
        // after reset release: half periods 7,3,1,0 make led the bit-reversed edge count
        va = '{'{4'h0, 4'h0, 4'h8, 4'h8}, '{4'h0, 4'h0, 4'h4, 4'hC}, '{4'h0, 4'h0, 4'hC, 4'h8},
               '{4'h0, 4'h0, 4'h2, 4'hE}, '{4'h0, 4'h0, 4'hA, 4'h8}, '{4'h0, 4'h0, 4'h6, 4'hC},
               '{4'h0, 4'h0, 4'hE, 4'h8}, '{4'h0, 4'h0, 4'h1, 4'hF}, '{4'h0, 4'h0, 4'h9, 4'h8},
               '{4'h2, 4'h2, 4'h7, 4'hC}, '{4'h2, 4'h2, 4'hF, 4'h8}, '{4'h0, 4'h0, 4'h3, 4'hE},
               '{4'h0, 4'h0, 4'hB, 4'h8}, '{4'h0, 4'h0, 4'h7, 4'hC}, '{4'h0, 4'h0, 4'hF, 4'h8},
               '{4'h0, 4'h0, 4'h0, 4'hF}};
        // after sync_restart: ch0/ch1 half 3, ch2 PWM duty 128, ch3 rewritten to half 1
        vb = '{'{4'h0, 4'h0, 4'h4, 4'h0}, '{4'h0, 4'h0, 4'hC, 4'h8}, '{4'h0, 4'h0, 4'hC, 4'h0},
               '{4'h0, 4'h0, 4'h7, 4'hB}, '{4'h0, 4'h0, 4'h7, 4'h0}, '{4'h0, 4'h0, 4'hF, 4'h8},
               '{4'h0, 4'h0, 4'hF, 4'h0}, '{4'h0, 4'h0, 4'h4, 4'hB}};

        repeat (3) @(posedge clk);
        #1;
        check("reset led", 32'(led), 0);
        check("reset tick", 32'(tick), 0);
        check("reset led6", 32'(led2), 0);
        check("reset tick6", 32'(tick2), 0);
        #2 rst = 1'b0;
        for (int k = 0; k < 16; k++) apply(va[k], "blink", k + 1);

        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst led", 32'(led), 0);
        check("async rst tick", 32'(tick), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        repeat (7) @(posedge clk);
        #1;
        write_cfg(2'd0, 2'b10, 8'd3, 8'd0);
        check("tc write led", 32'(led), 0);
        check("tc write tick", 32'(tick), 32'hE);
        for (int e = 9; e <= 16; e++) begin
            @(posedge clk); #1;
            check($sformatf("rehalf[%0d] led0", e), 32'(led[0]), 32'(e >= 12 && e < 16));
            check($sformatf("rehalf[%0d] tick0", e), 32'(tick[0]), 32'(e == 12 || e == 16));
        end

        write_cfg(2'd2, 2'b11, 8'd0, 8'd64);
        count_pwm("pwm duty64 highs", 64);
        write_cfg(2'd2, 2'b11, 8'd0, 8'd0);
        count_pwm("pwm duty0 highs", 0);
        write_cfg(2'd2, 2'b11, 8'd0, 8'd255);
        count_pwm("pwm duty255 highs", 255);
        write_cfg(2'd2, 2'b11, 8'd0, 8'd128);
        repeat (5) @(posedge clk);
        #1;

        sync_restart = 1'b1;
        write_cfg(2'd3, 2'b10, 8'd1, 8'd0);
        sync_restart = 1'b0;
        check("restart led", 32'(led & 4'hB), 0);
        check("restart tick", 32'(tick), 0);
        for (int k = 0; k < 8; k++) apply(vb[k], "restart", k + 1);
        for (int k = 9; k <= 129; k++) begin
            @(posedge clk); #1;
            if (k >= 128) check($sformatf("pwm restart[%0d] led2", k), 32'(led[2]), 32'(k == 128));
        end

        cfg_we2 = 1'b1; cfg_ch2 = 3'd5; cfg_mode = 2'b01;
        @(posedge clk); #1;
        cfg_we2 = 1'b0;
        check("ch5 write tick", 32'(tick2[5]), 0);
        @(posedge clk); #1;
        check("ch5 on led", 32'(led2[5]), 1);
        cfg_we2 = 1'b1; cfg_ch2 = 3'd6; cfg_mode = 2'b00;
        @(posedge clk); #1;
        cfg_ch2 = 3'd7;
        @(posedge clk); #1;
        cfg_we2 = 1'b0;
        @(posedge clk); #1;
        check("ch6/7 ignored led5", 32'(led2[5]), 1);
        check("ch6/7 ignored tick5", 32'(tick2[5]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
